// File: rtl/pack_extractor.sv
`default_nettype none
// ============================================================================
// Module   : pack_extractor
// Brief    : Header decode and payload forwarding after a preamble flag.
// Revision : 1.0 - initial release
// ============================================================================
module pack_extractor #(
   parameter int         cHDR_LEN = 16,
   parameter int         cLEN_W   = 12,
   parameter logic [3:0] cCHK_KEY = 4'hA
) (
   input  logic              iclk,
   input  logic              irst,
   input  logic [4:0]        idat,
   input  logic              ival,
   input  logic              isop,
   output logic [4:0]        odat,
   output logic              oval,
   output logic              osop,
   output logic              oeop,
   output logic [cLEN_W-1:0] olen,
   output logic              ohdr_err,
   output logic              obusy,
   output logic [15:0]       ofrm_cnt,
   output logic [15:0]       oerr_cnt
);

   localparam int                c_CHK_W   = cHDR_LEN - cLEN_W;
   localparam int                c_BC_W    = $clog2(cHDR_LEN);
   localparam logic [c_BC_W-1:0] c_BC_LAST = c_BC_W'(cHDR_LEN - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HEADER  = 2'd1,
      PAYLOAD = 2'd2
   } state_t;

   state_t              r_state;
   // One bit short of the header: the 16th bit arrives on the deciding cycle.
   logic [cHDR_LEN-2:0] r_hdr;
   logic [c_BC_W-1:0]   r_bitcnt;
   logic [cLEN_W-1:0]   r_rem;
   logic                r_first;

   logic [cHDR_LEN-1:0] w_hdr_next;
   logic [cLEN_W-1:0]   w_len;
   logic [c_CHK_W-1:0]  w_chk;
   logic [c_CHK_W-1:0]  w_chk_calc;
   logic                w_hdr_ok;

   always_comb begin
      w_hdr_next = {r_hdr, ~idat[4]};
      w_len      = w_hdr_next[cHDR_LEN-1 -: cLEN_W];
      w_chk      = w_hdr_next[c_CHK_W-1:0];
      w_chk_calc = c_CHK_W'(cCHK_KEY);
      for (int i = 0; i < cLEN_W / c_CHK_W; i++) begin
         w_chk_calc = w_chk_calc ^ w_len[i*c_CHK_W +: c_CHK_W];
      end
      w_hdr_ok   = (w_chk == w_chk_calc) && (w_len != '0);
   end

   assign obusy = (r_state != IDLE);

   always_ff @(posedge iclk or negedge irst) begin
      if (!irst) begin
         r_state  <= IDLE;
         r_hdr    <= '0;
         r_bitcnt <= '0;
         r_rem    <= '0;
         r_first  <= 1'b0;
         odat     <= '0;
         oval     <= 1'b0;
         osop     <= 1'b0;
         oeop     <= 1'b0;
         olen     <= '0;
         ohdr_err <= 1'b0;
         ofrm_cnt <= '0;
         oerr_cnt <= '0;
      end else begin
         oval     <= 1'b0;
         osop     <= 1'b0;
         oeop     <= 1'b0;
         ohdr_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (ival && isop) begin
                  r_state  <= HEADER;
                  r_bitcnt <= '0;
               end
            end
            HEADER: begin
               if (ival) begin
                  r_hdr    <= w_hdr_next[cHDR_LEN-2:0];
                  r_bitcnt <= r_bitcnt + 1'b1;
                  if (r_bitcnt == c_BC_LAST) begin
                     if (w_hdr_ok) begin
                        r_state <= PAYLOAD;
                        r_rem   <= w_len;
                        r_first <= 1'b1;
                     end else begin
                        r_state  <= IDLE;
                        ohdr_err <= 1'b1;
                        oerr_cnt <= oerr_cnt + 16'd1;
                     end
                  end
               end
            end
            PAYLOAD: begin
               if (ival) begin
                  oval    <= 1'b1;
                  odat    <= idat;
                  osop    <= r_first;
                  r_first <= 1'b0;
                  if (r_first) begin
                     olen <= r_rem;
                  end
                  r_rem <= r_rem - 1'b1;
                  if (r_rem == cLEN_W'(1)) begin
                     oeop     <= 1'b1;
                     ofrm_cnt <= ofrm_cnt + 16'd1;
                     r_state  <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pack_extractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_pack_extractor
// Brief    : Scoreboard bench for pack_extractor header decode and forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pack_extractor;

   logic        iclk = 1'b0;
   logic        irst = 1'b0;
   logic [4:0]  idat = '0;
   logic        ival = 1'b0;
   logic        isop = 1'b0;
   logic [4:0]  odat;
   logic        oval, osop, oeop, ohdr_err, obusy;
   logic [11:0] olen;
   logic [15:0] ofrm_cnt, oerr_cnt;

   pack_extractor dut (
      .iclk(iclk), .irst(irst), .idat(idat), .ival(ival), .isop(isop),
      .odat(odat), .oval(oval), .osop(osop), .oeop(oeop), .olen(olen),
      .ohdr_err(ohdr_err), .obusy(obusy), .ofrm_cnt(ofrm_cnt), .oerr_cnt(oerr_cnt)
   );

   always #5 iclk = ~iclk;

   typedef struct packed {
      logic [4:0]  dat;
      logic        sop;
      logic        eop;
      logic [11:0] len;
   } exp_t;

   exp_t q[$];
   exp_t m_e;
   int   n_checks  = 0;
   int   n_fail    = 0;
   int   n_hdr_err = 0;
   int   n_oval    = 0;

   // Output monitor: every forwarded sample must match the next expected entry.
   always @(negedge iclk) begin
      if (irst) begin
         if (ohdr_err) n_hdr_err++;
         if (oval) begin
            n_oval++;
            n_checks++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_oval: got odat=%h osop=%b oeop=%b, required no output", odat, osop, oeop);
            end else begin
               m_e = q.pop_front();
               if ({odat, osop, oeop} !== {m_e.dat, m_e.sop, m_e.eop} || (m_e.sop && olen !== m_e.len)) begin
                  n_fail++;
                  $display("FAIL payload_sample: got odat=%h osop=%b oeop=%b olen=%0d, required odat=%h osop=%b oeop=%b olen=%0d",
                           odat, osop, oeop, olen, m_e.dat, m_e.sop, m_e.eop, m_e.len);
               end
            end
         end
      end
   end

   task automatic send(input logic [4:0] d, input logic v, input logic s);
      idat = d; ival = v; isop = s;
      @(negedge iclk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) send(5'h00, 1'b0, 1'b0);
   endtask

   task automatic send_hdr(input logic [15:0] h);
      send(5'h00, 1'b1, 1'b1);
      for (int i = 15; i >= 0; i--) send({~h[i], 4'h0}, 1'b1, 1'b0);
   endtask

   task automatic pay(input logic [4:0] d, input logic first, input logic last,
                      input logic [11:0] len, input logic s);
      q.push_back('{dat: d, sop: first, eop: last, len: len});
      send(d, 1'b1, s);
   endtask

   task automatic test_reset;
      idle(3);
      n_checks++;
      if ({oval, osop, oeop, ohdr_err, obusy} !== 5'b0) begin
         n_fail++; $display("FAIL reset_flags: got %b, required 00000", {oval, osop, oeop, ohdr_err, obusy});
      end
      n_checks++;
      if (odat !== 5'h0 || olen !== 12'h0) begin
         n_fail++; $display("FAIL reset_data: got odat=%h olen=%h, required 0 0", odat, olen);
      end
      n_checks++;
      if (ofrm_cnt !== 16'h0 || oerr_cnt !== 16'h0) begin
         n_fail++; $display("FAIL reset_counters: got %0d %0d, required 0 0", ofrm_cnt, oerr_cnt);
      end
      irst = 1'b1;
      idle(2);
   endtask

   task automatic test_good_frame;
      int v0 = n_oval, e0 = n_hdr_err;
      send_hdr(16'h005F);
      for (int i = 1; i <= 5; i++) pay(5'(i), i == 1, i == 5, 12'd5, 1'b0);
      idle(3);
      n_checks++;
      if (ofrm_cnt !== 16'd1) begin n_fail++; $display("FAIL good_frm_cnt: got %0d, required 1", ofrm_cnt); end
      n_checks++;
      if (n_oval - v0 != 5) begin n_fail++; $display("FAIL good_oval_count: got %0d, required 5", n_oval - v0); end
      n_checks++;
      if (q.size() != 0 || obusy !== 1'b0) begin
         n_fail++; $display("FAIL good_end: got pending=%0d obusy=%b, required 0 0", q.size(), obusy);
      end
      n_checks++;
      if (n_hdr_err != e0 || oerr_cnt !== 16'd0) begin
         n_fail++; $display("FAIL good_no_err: got pulses=%0d oerr_cnt=%0d, required 0 0", n_hdr_err - e0, oerr_cnt);
      end
   endtask

   task automatic test_bad_chk;
      int v0 = n_oval, e0 = n_hdr_err;
      logic [15:0] h = 16'h0050;
      send(5'h00, 1'b1, 1'b1);
      n_checks++;
      if (obusy !== 1'b1) begin n_fail++; $display("FAIL bad_busy_in_hdr: got %b, required 1", obusy); end
      for (int i = 15; i >= 0; i--) send({~h[i], 4'h0}, 1'b1, 1'b0);
      idle(3);
      n_checks++;
      if (n_hdr_err - e0 != 1) begin n_fail++; $display("FAIL bad_err_pulses: got %0d, required 1", n_hdr_err - e0); end
      n_checks++;
      if (oerr_cnt !== 16'd1) begin n_fail++; $display("FAIL bad_err_cnt: got %0d, required 1", oerr_cnt); end
      n_checks++;
      if (obusy !== 1'b0 || n_oval != v0) begin
         n_fail++; $display("FAIL bad_after: got obusy=%b ovals=%0d, required 0 0", obusy, n_oval - v0);
      end
   endtask

   task automatic test_len0_len1;
      int e0 = n_hdr_err;
      send_hdr(16'h000A);
      idle(2);
      n_checks++;
      if (n_hdr_err - e0 != 1 || oerr_cnt !== 16'd2) begin
         n_fail++; $display("FAIL len0_err: got pulses=%0d oerr_cnt=%0d, required 1 2", n_hdr_err - e0, oerr_cnt);
      end
      send_hdr(16'h001B);
      pay(5'h1A, 1'b1, 1'b1, 12'd1, 1'b0);
      idle(2);
      n_checks++;
      if (ofrm_cnt !== 16'd2 || q.size() != 0) begin
         n_fail++; $display("FAIL len1_frame: got frm=%0d pending=%0d, required 2 0", ofrm_cnt, q.size());
      end
   endtask

   task automatic test_gaps;
      int v0;
      send(5'h00, 1'b0, 1'b1);
      idle(2);
      n_checks++;
      if (obusy !== 1'b0) begin n_fail++; $display("FAIL gap_sop_unqualified: got obusy=%b, required 0", obusy); end
      v0 = n_oval;
      send_hdr(16'h005F);
      for (int i = 1; i <= 5; i++) begin
         pay(5'(5'h10 + i), i == 1, i == 5, 12'd5, i == 3);
         send(5'h1F, 1'b0, i == 2);
      end
      idle(2);
      n_checks++;
      if (n_oval - v0 != 5 || ofrm_cnt !== 16'd3) begin
         n_fail++; $display("FAIL gap_frame: got ovals=%0d frm=%0d, required 5 3", n_oval - v0, ofrm_cnt);
      end
   endtask

   task automatic test_back_to_back;
      send_hdr(16'h001B);
      pay(5'h07, 1'b1, 1'b1, 12'd1, 1'b1);
      idle(3);
      n_checks++;
      if (obusy !== 1'b0 || ofrm_cnt !== 16'd4) begin
         n_fail++; $display("FAIL sop_on_eop: got obusy=%b frm=%0d, required 0 4", obusy, ofrm_cnt);
      end
      send_hdr(16'h001B);
      pay(5'h08, 1'b1, 1'b1, 12'd1, 1'b0);
      idle(2);
      n_checks++;
      if (ofrm_cnt !== 16'd5 || q.size() != 0) begin
         n_fail++; $display("FAIL next_frame: got frm=%0d pending=%0d, required 5 0", ofrm_cnt, q.size());
      end
   endtask

   task automatic test_reset_mid;
      int v0;
      send_hdr(16'h0082);
      pay(5'h01, 1'b1, 1'b0, 12'd8, 1'b0);
      pay(5'h02, 1'b0, 1'b0, 12'd8, 1'b0);
      #2 irst = 1'b0;
      #1;
      n_checks++;
      if ({oval, osop, oeop, ohdr_err, obusy} !== 5'b0 || odat !== 5'h0 || olen !== 12'h0) begin
         n_fail++; $display("FAIL midreset_outputs: got flags=%b odat=%h olen=%h, required 0", {oval, osop, oeop, ohdr_err, obusy}, odat, olen);
      end
      n_checks++;
      if (ofrm_cnt !== 16'h0 || oerr_cnt !== 16'h0) begin
         n_fail++; $display("FAIL midreset_counters: got %0d %0d, required 0 0", ofrm_cnt, oerr_cnt);
      end
      @(negedge iclk);
      v0 = n_oval;
      for (int i = 3; i <= 5; i++) send(5'(i), 1'b1, 1'b0);
      irst = 1'b1;
      for (int i = 6; i <= 8; i++) send(5'(i), 1'b1, 1'b0);
      idle(2);
      n_checks++;
      if (obusy !== 1'b0 || n_oval != v0 || ofrm_cnt !== 16'h0) begin
         n_fail++; $display("FAIL midreset_wait: got obusy=%b ovals=%0d frm=%0d, required 0 0 0", obusy, n_oval - v0, ofrm_cnt);
      end
      send_hdr(16'h0039);
      for (int i = 1; i <= 3; i++) pay(5'(5'h08 + i), i == 1, i == 3, 12'd3, 1'b0);
      idle(2);
      n_checks++;
      if (ofrm_cnt !== 16'd1 || oerr_cnt !== 16'd0 || q.size() != 0) begin
         n_fail++; $display("FAIL midreset_recover: got frm=%0d err=%0d pending=%0d, required 1 0 0", ofrm_cnt, oerr_cnt, q.size());
      end
   endtask

   initial begin
      test_reset;
      test_good_frame;
      test_bad_chk;
      test_len0_len1;
      test_gaps;
      test_back_to_back;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
